// File: rtl/soc_reset_sequencer.sv
// Reset merger and CPU-enable sequencer: key/JTAG/watchdog sources -> stretched soc_reset_o, delayed cpu_en_o.
// Optional watchdog is built only when RST_SEQ_WATCHDOG_EN is defined.
module soc_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 16,
  parameter int ENA_DELAY       = 8,
  parameter int WDT_CYCLES      = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_reset_i,
  input  logic       jtag_reset_i,
  input  logic       wdt_kick_i,
  output logic       soc_reset_o,
  output logic       cpu_en_o,
  output logic       reset_led_o,
  output logic [1:0] reset_cause_o
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int ENA_W  = $clog2(ENA_DELAY + 1);
  localparam int WDT_W  = $clog2(WDT_CYCLES + 1);

  typedef enum logic [1:0] {ST_ASSERT, ST_WAIT_EN, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] key_sync_q, key_sync_d;
  logic [SYNC_STAGES-1:0] jtag_sync_q, jtag_sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   key_d_q, key_d_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [ENA_W-1:0]       ena_cnt_q, ena_cnt_d;
  logic [1:0]             cause_q, cause_d;
  logic [2:0]             src_prev_q;
  logic                   soc_reset_q, soc_reset_d;
  logic                   cpu_en_q, cpu_en_d;
  logic                   led_q, led_d;

  logic       key_s, jtag_s, wdt_fire, src;
  logic [2:0] src_vec, src_rise;

  // Source vector ordering {jtag, key, wdt} doubles as the cause priority.
  function automatic logic [1:0] cause_of(input logic [2:0] v);
    logic [1:0] c;
    c = 2'd0;
    if (v[2])      c = 2'd2;
    else if (v[1]) c = 2'd1;
    else if (v[0]) c = 2'd3;
    return c;
  endfunction

  assign key_s    = key_sync_q[SYNC_STAGES-1];
  assign jtag_s   = jtag_sync_q[SYNC_STAGES-1];
  assign src_vec  = {jtag_s, key_d_q, wdt_fire};
  assign src      = |src_vec;
  assign src_rise = src_vec & ~src_prev_q;

  always_comb begin
    key_sync_d  = {key_sync_q[SYNC_STAGES-2:0], key_reset_i};
    jtag_sync_d = {jtag_sync_q[SYNC_STAGES-2:0], jtag_reset_i};
    // Any return of key_s to the accepted level restarts the debounce window.
    key_d_d  = key_d_q;
    db_cnt_d = '0;
    if (key_s != key_d_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) key_d_d = key_s;
      else                                        db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    ena_cnt_d  = ena_cnt_q;
    cause_d    = cause_q;
    case (state_q)
      ST_ASSERT: begin
        ena_cnt_d = '0;
        if (src) begin
          hold_cnt_d = '0;
          if (|src_rise) cause_d = cause_of(src_rise);
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d    = ST_WAIT_EN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_WAIT_EN: begin
        if (src) begin
          state_d    = ST_ASSERT;
          hold_cnt_d = '0;
          ena_cnt_d  = '0;
          cause_d    = cause_of(src_vec);
        end else if (ena_cnt_q == ENA_W'(ENA_DELAY - 1)) begin
          state_d   = ST_RUN;
          ena_cnt_d = '0;
        end else begin
          ena_cnt_d = ena_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (src) begin
          state_d    = ST_ASSERT;
          hold_cnt_d = '0;
          cause_d    = cause_of(src_vec);
        end
      end
      default: state_d = ST_ASSERT;
    endcase
    // Outputs come from the next state so they flip on the same edge as the FSM.
    soc_reset_d = (state_d == ST_ASSERT);
    cpu_en_d    = (state_d == ST_RUN);
    led_d       = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ASSERT;
      key_sync_q  <= '0;
      jtag_sync_q <= '0;
      db_cnt_q    <= '0;
      key_d_q     <= 1'b0;
      hold_cnt_q  <= '0;
      ena_cnt_q   <= '0;
      cause_q     <= 2'd0;
      src_prev_q  <= '0;
      soc_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      led_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      key_sync_q  <= key_sync_d;
      jtag_sync_q <= jtag_sync_d;
      db_cnt_q    <= db_cnt_d;
      key_d_q     <= key_d_d;
      hold_cnt_q  <= hold_cnt_d;
      ena_cnt_q   <= ena_cnt_d;
      cause_q     <= cause_d;
      src_prev_q  <= src_vec;
      soc_reset_q <= soc_reset_d;
      cpu_en_q    <= cpu_en_d;
      led_q       <= led_d;
    end
  end

`ifdef RST_SEQ_WATCHDOG_EN
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

  // Counter is zero whenever RUN is not held across the edge, so fire is a single-cycle pulse.
  assign wdt_fire = (state_q == ST_RUN) && (wdt_cnt_q == WDT_W'(WDT_CYCLES));

  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    if (state_q != ST_RUN || state_d != ST_RUN || wdt_kick_i) wdt_cnt_d = '0;
    else if (wdt_cnt_q != WDT_W'(WDT_CYCLES))                 wdt_cnt_d = wdt_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) wdt_cnt_q <= '0;
    else       wdt_cnt_q <= wdt_cnt_d;
  end
`else
  logic [WDT_W-1:0] unused_wdt;
  assign unused_wdt = {WDT_W{wdt_kick_i}};
  assign wdt_fire   = 1'b0;
`endif

  assign soc_reset_o   = soc_reset_q;
  assign cpu_en_o      = cpu_en_q;
  assign reset_led_o   = led_q;
  assign reset_cause_o = cause_q;
endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Scoreboard bench: each scenario queues expected output-change events, a negedge monitor queues observed ones.
module tb_soc_reset_sequencer;
  localparam int SYNC = 2, DEB = 4, HOLD = 16, ENA = 8, WDT = 32;

  logic       clk = 1'b0, reset = 1'b1;
  logic       key_reset_i = 1'b0, jtag_reset_i = 1'b0, wdt_kick_i = 1'b0;
  logic       soc_reset_o, cpu_en_o, reset_led_o;
  logic [1:0] reset_cause_o;

  int cyc = 0, n_checks = 0, n_fail = 0;

  typedef struct packed {
    int         cyc;
    logic       soc;
    logic       en;
    logic       led;
    logic [1:0] cause;
  } ev_t;

  ev_t        exp_q[$], obs_q[$];
  logic [4:0] prev_out = 'x;

  soc_reset_sequencer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .ENA_DELAY(ENA), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .reset(reset), .key_reset_i(key_reset_i), .jtag_reset_i(jtag_reset_i),
    .wdt_kick_i(wdt_kick_i), .soc_reset_o(soc_reset_o), .cpu_en_o(cpu_en_o),
    .reset_led_o(reset_led_o), .reset_cause_o(reset_cause_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every change of the output bundle becomes an observed event stamped with the edge count.
  always @(negedge clk) begin
    if ({soc_reset_o, cpu_en_o, reset_led_o, reset_cause_o} !== prev_out) begin
      obs_q.push_back(ev_t'{cyc: cyc, soc: soc_reset_o, en: cpu_en_o, led: reset_led_o, cause: reset_cause_o});
      prev_out = {soc_reset_o, cpu_en_o, reset_led_o, reset_cause_o};
    end
  end

  function automatic ev_t mk(input int c, input logic s, input logic e, input logic l, input logic [1:0] ca);
    return ev_t'{cyc: c, soc: s, en: e, led: l, cause: ca};
  endfunction

  task automatic start_scenario(output int t0);
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    t0 = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (soc_reset_o !== 1'b1) begin n_fail++; $display("FAIL reset_soc: got %b want 1", soc_reset_o); end
    n_checks++; if (cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", cpu_en_o); end
    n_checks++; if (reset_led_o !== 1'b1) begin n_fail++; $display("FAIL reset_led: got %b want 1", reset_led_o); end
    n_checks++; if (reset_cause_o !== 2'd0) begin n_fail++; $display("FAIL reset_cause: got %0d want 0", reset_cause_o); end
  endtask

  task automatic test_power_on();
    int t0; ev_t e, o;
    start_scenario(t0);
    reset = 1'b0;
    exp_q.push_back(mk(t0 + HOLD, 0, 0, 1, 2'd0));
    exp_q.push_back(mk(t0 + HOLD + ENA, 0, 1, 0, 2'd0));
    repeat (30) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL power_on: missing event, want cyc=%0d soc=%b en=%b led=%b cause=%0d", e.cyc, e.soc, e.en, e.led, e.cause); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL power_on: got cyc=%0d soc=%b en=%b led=%b cause=%0d want cyc=%0d soc=%b en=%b led=%b cause=%0d", o.cyc, o.soc, o.en, o.led, o.cause, e.cyc, e.soc, e.en, e.led, e.cause); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL power_on: %0d extra events, first at cyc=%0d want 0", obs_q.size(), obs_q[0].cyc); end
  endtask

  task automatic test_jtag_pulse();
    int t0; ev_t e, o;
    start_scenario(t0);
    jtag_reset_i = 1'b1; @(negedge clk); jtag_reset_i = 1'b0;
    exp_q.push_back(mk(t0 + SYNC + 1, 1, 0, 1, 2'd2));
    exp_q.push_back(mk(t0 + SYNC + 1 + HOLD, 0, 0, 1, 2'd2));
    exp_q.push_back(mk(t0 + SYNC + 1 + HOLD + ENA, 0, 1, 0, 2'd2));
    repeat (35) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL jtag_pulse: missing event, want cyc=%0d soc=%b en=%b led=%b cause=%0d", e.cyc, e.soc, e.en, e.led, e.cause); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL jtag_pulse: got cyc=%0d soc=%b en=%b led=%b cause=%0d want cyc=%0d soc=%b en=%b led=%b cause=%0d", o.cyc, o.soc, o.en, o.led, o.cause, e.cyc, e.soc, e.en, e.led, e.cause); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL jtag_pulse: %0d extra events, first at cyc=%0d want 0", obs_q.size(), obs_q[0].cyc); end
  endtask

  task automatic test_reassert_wait_en();
    int t0; ev_t e, o;
    start_scenario(t0);
    jtag_reset_i = 1'b1; @(negedge clk); jtag_reset_i = 1'b0;
    // soc_reset_o falls at t0+19; re-hit JTAG 3 cycles later, mid WAIT_EN.
    repeat (21) @(negedge clk);
    jtag_reset_i = 1'b1; @(negedge clk); jtag_reset_i = 1'b0;
    exp_q.push_back(mk(t0 + 3, 1, 0, 1, 2'd2));
    exp_q.push_back(mk(t0 + 3 + HOLD, 0, 0, 1, 2'd2));
    exp_q.push_back(mk(t0 + 25, 1, 0, 1, 2'd2));
    exp_q.push_back(mk(t0 + 25 + HOLD, 0, 0, 1, 2'd2));
    exp_q.push_back(mk(t0 + 25 + HOLD + ENA, 0, 1, 0, 2'd2));
    repeat (35) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL reassert_wait_en: missing event, want cyc=%0d soc=%b en=%b led=%b cause=%0d", e.cyc, e.soc, e.en, e.led, e.cause); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL reassert_wait_en: got cyc=%0d soc=%b en=%b led=%b cause=%0d want cyc=%0d soc=%b en=%b led=%b cause=%0d", o.cyc, o.soc, o.en, o.led, o.cause, e.cyc, e.soc, e.en, e.led, e.cause); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reassert_wait_en: %0d extra events, first at cyc=%0d want 0", obs_q.size(), obs_q[0].cyc); end
  endtask

  task automatic test_key_bounce();
    int t0, k; ev_t e, o;
    start_scenario(t0);
    for (int i = 0; i < 10; i++) begin
      key_reset_i = 1'b1; repeat (2) @(negedge clk);
      key_reset_i = 1'b0; repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    k = cyc;
    key_reset_i = 1'b1; repeat (10) @(negedge clk); key_reset_i = 1'b0;
    // Release is debounced too: key_d falls at k+16, then the full hold.
    exp_q.push_back(mk(k + SYNC + DEB + 1, 1, 0, 1, 2'd1));
    exp_q.push_back(mk(k + 16 + HOLD, 0, 0, 1, 2'd1));
    exp_q.push_back(mk(k + 16 + HOLD + ENA, 0, 1, 0, 2'd1));
    repeat (38) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL key_bounce: missing event, want cyc=%0d soc=%b en=%b led=%b cause=%0d", e.cyc, e.soc, e.en, e.led, e.cause); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL key_bounce: got cyc=%0d soc=%b en=%b led=%b cause=%0d want cyc=%0d soc=%b en=%b led=%b cause=%0d", o.cyc, o.soc, o.en, o.led, o.cause, e.cyc, e.soc, e.en, e.led, e.cause); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL key_bounce: %0d extra events, first at cyc=%0d want 0", obs_q.size(), obs_q[0].cyc); end
  endtask

  task automatic test_simultaneous();
    int t0; ev_t e, o;
    start_scenario(t0);
    // JTAG is launched DEB cycles after the key so both sources reach the FSM on the same edge.
    key_reset_i = 1'b1; repeat (DEB) @(negedge clk);
    jtag_reset_i = 1'b1; @(negedge clk); jtag_reset_i = 1'b0;
    repeat (5) @(negedge clk); key_reset_i = 1'b0;
    exp_q.push_back(mk(t0 + SYNC + DEB + 1, 1, 0, 1, 2'd2));
    exp_q.push_back(mk(t0 + 16 + HOLD, 0, 0, 1, 2'd2));
    exp_q.push_back(mk(t0 + 16 + HOLD + ENA, 0, 1, 0, 2'd2));
    repeat (38) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL simultaneous: missing event, want cyc=%0d soc=%b en=%b led=%b cause=%0d", e.cyc, e.soc, e.en, e.led, e.cause); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL simultaneous: got cyc=%0d soc=%b en=%b led=%b cause=%0d want cyc=%0d soc=%b en=%b led=%b cause=%0d", o.cyc, o.soc, o.en, o.led, o.cause, e.cyc, e.soc, e.en, e.led, e.cause); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL simultaneous: %0d extra events, first at cyc=%0d want 0", obs_q.size(), obs_q[0].cyc); end
  endtask

`ifdef RST_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    int t0, tl; ev_t e, o;
    start_scenario(t0);
    tl = t0;
    for (int i = 0; i < 5; i++) begin
      tl = cyc;
      wdt_kick_i = 1'b1; @(negedge clk); wdt_kick_i = 1'b0;
      repeat (19) @(negedge clk);
    end
    // Last kick lands at edge tl+1; the counter hits WDT at tl+33 and ASSERT follows.
    exp_q.push_back(mk(tl + WDT + 2, 1, 0, 1, 2'd3));
    exp_q.push_back(mk(tl + WDT + 2 + HOLD, 0, 0, 1, 2'd3));
    exp_q.push_back(mk(tl + WDT + 2 + HOLD + ENA, 0, 1, 0, 2'd3));
    repeat (65) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL watchdog: missing event, want cyc=%0d soc=%b en=%b led=%b cause=%0d", e.cyc, e.soc, e.en, e.led, e.cause); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL watchdog: got cyc=%0d soc=%b en=%b led=%b cause=%0d want cyc=%0d soc=%b en=%b led=%b cause=%0d", o.cyc, o.soc, o.en, o.led, o.cause, e.cyc, e.soc, e.en, e.led, e.cause); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL watchdog: %0d extra events, first at cyc=%0d want 0", obs_q.size(), obs_q[0].cyc); end
  endtask
`endif

  task automatic test_global_reset_mid_hold();
    int t0, r0; ev_t e, o;
    start_scenario(t0);
    jtag_reset_i = 1'b1; @(negedge clk); jtag_reset_i = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1; @(negedge clk);
    n_checks++; if (soc_reset_o !== 1'b1) begin n_fail++; $display("FAIL midhold_soc: got %b want 1", soc_reset_o); end
    n_checks++; if (cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL midhold_en: got %b want 0", cpu_en_o); end
    n_checks++; if (reset_led_o !== 1'b1) begin n_fail++; $display("FAIL midhold_led: got %b want 1", reset_led_o); end
    n_checks++; if (reset_cause_o !== 2'd0) begin n_fail++; $display("FAIL midhold_cause: got %0d want 0", reset_cause_o); end
    r0 = cyc; reset = 1'b0;
    exp_q.push_back(mk(t0 + 3, 1, 0, 1, 2'd2));
    exp_q.push_back(mk(t0 + 9, 1, 0, 1, 2'd0));
    exp_q.push_back(mk(r0 + HOLD, 0, 0, 1, 2'd0));
    exp_q.push_back(mk(r0 + HOLD + ENA, 0, 1, 0, 2'd0));
    repeat (30) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL global_reset: missing event, want cyc=%0d soc=%b en=%b led=%b cause=%0d", e.cyc, e.soc, e.en, e.led, e.cause); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL global_reset: got cyc=%0d soc=%b en=%b led=%b cause=%0d want cyc=%0d soc=%b en=%b led=%b cause=%0d", o.cyc, o.soc, o.en, o.led, o.cause, e.cyc, e.soc, e.en, e.led, e.cause); end end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL global_reset: %0d extra events, first at cyc=%0d want 0", obs_q.size(), obs_q[0].cyc); end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_jtag_pulse();
    test_reassert_wait_en();
    test_key_bounce();
    test_simultaneous();
`ifdef RST_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    test_global_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
